// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone classic-cycle initiator.
// Holds the FSM state encoding and the packed command latch layout.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// 8-bit watchdog for a pending bus cycle; expire_o is high while the count
// sits at TIMEOUT_CYCLES-1. Instantiated only when WB_MASTER_TIMEOUT_EN is set.
module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Saturates at LAST so a stalled FSM cannot wrap back into a quiet state.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone classic initiator: one command -> one bus cycle -> one
// response strobe. Optional watchdog abort is built when WB_MASTER_TIMEOUT_EN is defined.
import wb_pkg::*;

module wishbone_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                CLK_I,
    input  logic                RST_I,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [WB_ADR_W-1:0] cmd_adr,
    input  logic [WB_DAT_W-1:0] cmd_dat,
    input  logic [WB_SEL_W-1:0] cmd_sel,
    output logic                rsp_valid,
    output logic [WB_DAT_W-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    output logic [WB_ADR_W-1:0] ADR_O,
    output logic [WB_SEL_W-1:0] SEL_O,
    output logic [WB_DAT_W-1:0] DAT_O,
    input  logic [WB_DAT_W-1:0] DAT_I,
    input  logic                ACK_I,
    output logic [1:0]          state_o
);

    // Handshake: a command transfers on any rising edge where cmd_valid && cmd_ready;
    // rsp_valid is a single-cycle strobe with no back-pressure.

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wishbone_master: TIMEOUT_CYCLES must be in 2..255");
    end

    wb_state_e           state_q, state_d;
    wb_cmd_t             cmd_q, cmd_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    logic wd_clear;
    logic wd_enable;
    logic wd_expire;

    assign wd_clear  = (state_q == ST_IDLE) && cmd_valid;
    assign wd_enable = (state_q == ST_BUS) && !ACK_I;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (CLK_I),
        .rst_i   (RST_I),
        .clear_i (wd_clear),
        .enable_i(wd_enable),
        .expire_o(wd_expire)
    );

    // ACK has priority: the abort only fires on a cycle the slave left unanswered.
    assign timeout_hit = (state_q == ST_BUS) && wd_expire && !ACK_I;
    assign rsp_err     = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d.we  = cmd_we;
                    cmd_d.adr = cmd_adr;
                    // Reads put zero on the data bus, so only writes carry payload.
                    cmd_d.dat = cmd_we ? cmd_dat : '0;
                    cmd_d.sel = cmd_sel;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = cmd_we;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                if (ACK_I) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = cmd_q.we ? '0 : DAT_I;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_d   = 1'b1;
`endif
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign CYC_O     = cyc_q;
    assign STB_O     = stb_q;
    assign WE_O      = we_q;
    assign ADR_O     = cmd_q.adr;
    assign SEL_O     = cmd_q.sel;
    assign DAT_O     = cmd_q.dat;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master; timeout scenarios run when WB_MASTER_TIMEOUT_EN is set.
module tb_wishbone_master;
    import wb_pkg::*;

    localparam int TO = 4;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I = '0;
    logic        ACK_I = 1'b0;
    logic [1:0]  state_o;

    int          checks = 0;
    int          passed = 0;
    logic [31:0] slave_mem = '0;
    logic [31:0] exp_q[$];

    wishbone_master #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
        .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .state_o(state_o)
    );

    // Clock / reset
    always #5 CLK_I = ~CLK_I;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish before 200000ns");
        $fatal(1, "simulation did not terminate");
    end

    task automatic test_reset();
        RST_I = 1'b1;
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        RST_I = 1'b0;
        checks++;
        if ({CYC_O, STB_O, WE_O, rsp_valid, rsp_err} !== 5'b00000)
            $display("FAIL reset_ctrl: got %b want 00000", {CYC_O, STB_O, WE_O, rsp_valid, rsp_err});
        else passed++;
        checks++;
        if ({ADR_O, DAT_O, SEL_O, rsp_dat} !== 100'd0)
            $display("FAIL reset_data: got adr=%h dat=%h sel=%h rsp_dat=%h want all 0", ADR_O, DAT_O, SEL_O, rsp_dat);
        else passed++;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready);
        else passed++;
        checks++;
        if (state_o !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE);
        else passed++;
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h10; cmd_dat = 32'hDEADBEEF; cmd_sel = 4'hF;
        @(negedge CLK_I);
        cmd_valid = 1'b0; cmd_dat = 32'h0; cmd_adr = 32'h0; cmd_sel = 4'h0;
        checks++;
        if ({CYC_O, STB_O, WE_O, cmd_ready} !== 4'b1110)
            $display("FAIL write_bus_ctrl: got %b want 1110", {CYC_O, STB_O, WE_O, cmd_ready});
        else passed++;
        checks++;
        if (ADR_O !== 32'h10 || DAT_O !== 32'hDEADBEEF || SEL_O !== 4'hF)
            $display("FAIL write_bus_data: got adr=%h dat=%h sel=%h want 10 deadbeef f", ADR_O, DAT_O, SEL_O);
        else passed++;
        ACK_I = 1'b1;
        slave_mem = DAT_O;
        @(negedge CLK_I);
        ACK_I = 1'b0;
        checks++;
        if ({CYC_O, STB_O, rsp_valid, rsp_err} !== 4'b0010)
            $display("FAIL write_rsp_ctrl: got %b want 0010", {CYC_O, STB_O, rsp_valid, rsp_err});
        else passed++;
        checks++;
        if (rsp_dat !== 32'h0) $display("FAIL write_rsp_dat: got %h want 0", rsp_dat);
        else passed++;
        @(negedge CLK_I);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL write_turnaround: got valid/ready %b want 01", {rsp_valid, cmd_ready});
        else passed++;
    endtask

    task automatic test_read_wait();
        int stb_cycles;
        stb_cycles = 0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h10; cmd_dat = 32'hFFFFFFFF; cmd_sel = 4'hF;
        @(negedge CLK_I);
        cmd_valid = 1'b0;
        checks++;
        if (WE_O !== 1'b0 || DAT_O !== 32'h0 || ADR_O !== 32'h10)
            $display("FAIL read_bus: got we=%b dat=%h adr=%h want 0 0 10", WE_O, DAT_O, ADR_O);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (STB_O === 1'b1) stb_cycles++;
            if (i == 2) begin
                ACK_I = 1'b1;
                DAT_I = slave_mem;
            end
            @(negedge CLK_I);
        end
        DAT_I = 32'hA5A5A5A5;
        checks++;
        if (stb_cycles != 3) $display("FAIL read_stb_len: got %0d want 3", stb_cycles);
        else passed++;
        checks++;
        if ({STB_O, rsp_valid, rsp_err} !== 3'b010 || rsp_dat !== 32'hDEADBEEF)
            $display("FAIL read_rsp: got stb/v/e=%b dat=%h want 010 deadbeef", {STB_O, rsp_valid, rsp_err}, rsp_dat);
        else passed++;
        // ACK held high after the cycle ended must not disturb anything.
        @(negedge CLK_I);
        ACK_I = 1'b0;
        checks++;
        if ({STB_O, rsp_valid} !== 2'b00 || rsp_dat !== 32'hDEADBEEF)
            $display("FAIL read_stray_ack: got stb/v=%b dat=%h want 00 deadbeef", {STB_O, rsp_valid}, rsp_dat);
        else passed++;
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int stb_cycles;
        stb_cycles = 0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h40; cmd_sel = 4'hF;
        ACK_I = 1'b0;
        @(negedge CLK_I);
        cmd_valid = 1'b0;
        while (STB_O === 1'b1 && stb_cycles < 50) begin
            stb_cycles++;
            @(negedge CLK_I);
        end
        checks++;
        if (stb_cycles != TO) $display("FAIL timeout_stb_len: got %0d want %0d", stb_cycles, TO);
        else passed++;
        checks++;
        if ({CYC_O, rsp_valid, rsp_err} !== 3'b011 || rsp_dat !== 32'h0)
            $display("FAIL timeout_rsp: got cyc/v/e=%b dat=%h want 011 0", {CYC_O, rsp_valid, rsp_err}, rsp_dat);
        else passed++;
        @(negedge CLK_I);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL timeout_turnaround: got %b want 01", {rsp_valid, cmd_ready});
        else passed++;
    endtask

    task automatic test_ack_at_timeout();
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h44; cmd_sel = 4'hF;
        @(negedge CLK_I);
        cmd_valid = 1'b0;
        repeat (TO - 1) @(negedge CLK_I);
        checks++;
        if (STB_O !== 1'b1) $display("FAIL ack_to_stb: got %b want 1 in cycle %0d", STB_O, TO);
        else passed++;
        ACK_I = 1'b1;
        DAT_I = 32'h12345678;
        @(negedge CLK_I);
        ACK_I = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_dat !== 32'h12345678)
            $display("FAIL ack_to_rsp: got v/e=%b dat=%h want 10 12345678", {rsp_valid, rsp_err}, rsp_dat);
        else passed++;
        @(negedge CLK_I);
    endtask
`else
    task automatic test_no_timeout();
        logic seen;
        seen = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h40; cmd_sel = 4'hF;
        @(negedge CLK_I);
        cmd_valid = 1'b0;
        repeat (40) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(negedge CLK_I);
        end
        checks++;
        if (STB_O !== 1'b1 || seen !== 1'b0)
            $display("FAIL no_timeout_wait: got stb=%b rsp_seen=%b want 1 0", STB_O, seen);
        else passed++;
        ACK_I = 1'b1;
        DAT_I = 32'hCAFEF00D;
        @(negedge CLK_I);
        ACK_I = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_dat !== 32'hCAFEF00D)
            $display("FAIL no_timeout_rsp: got v/e=%b dat=%h want 10 cafef00d", {rsp_valid, rsp_err}, rsp_dat);
        else passed++;
        @(negedge CLK_I);
    endtask
`endif

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h80; cmd_dat = 32'h11112222; cmd_sel = 4'hF;
        @(negedge CLK_I);
        cmd_valid = 1'b0;
        checks++;
        if (STB_O !== 1'b1) $display("FAIL mid_rst_pre: got stb=%b want 1", STB_O);
        else passed++;
        #2 RST_I = 1'b1;
        #1;
        checks++;
        if ({CYC_O, STB_O} !== 2'b00) $display("FAIL mid_rst_async: got cyc/stb=%b want 00", {CYC_O, STB_O});
        else passed++;
        repeat (3) begin
            @(negedge CLK_I);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        RST_I = 1'b0;
        repeat (3) begin
            @(negedge CLK_I);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL mid_rst_no_rsp: got rsp_seen=%b ready=%b want 0 1", seen, cmd_ready);
        else passed++;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h24; cmd_dat = 32'h0BADCAFE; cmd_sel = 4'h3;
        @(negedge CLK_I);
        cmd_valid = 1'b0;
        checks++;
        if ({CYC_O, STB_O, WE_O} !== 3'b111 || ADR_O !== 32'h24 || DAT_O !== 32'h0BADCAFE || SEL_O !== 4'h3)
            $display("FAIL mid_rst_next_bus: got ctl=%b adr=%h dat=%h sel=%h want 111 24 0badcafe 3",
                     {CYC_O, STB_O, WE_O}, ADR_O, DAT_O, SEL_O);
        else passed++;
        ACK_I = 1'b1;
        @(negedge CLK_I);
        ACK_I = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_dat !== 32'h0)
            $display("FAIL mid_rst_next_rsp: got v/e=%b dat=%h want 10 0", {rsp_valid, rsp_err}, rsp_dat);
        else passed++;
        @(negedge CLK_I);
    endtask

    task automatic test_back_to_back();
        logic [8:0]  ready_vec;
        logic [8:0]  rsp_vec;
        logic [31:0] exp_adr;
        int          k;
        ready_vec = '0;
        rsp_vec = '0;
        k = 0;
        exp_q.delete();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF;
        for (int i = 0; i < 9; i++) begin
            ready_vec[i] = cmd_ready;
            rsp_vec[i] = rsp_valid;
            if (cmd_ready === 1'b1) begin
                cmd_adr = 32'h100 + 32'(4 * k);
                cmd_dat = 32'(k);
                exp_q.push_back(cmd_adr);
                k++;
            end
            if (STB_O === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_adr: got adr=%h want no bus cycle", ADR_O);
                end else begin
                    exp_adr = exp_q.pop_front();
                    if (ADR_O !== exp_adr) $display("FAIL b2b_adr: got %h want %h", ADR_O, exp_adr);
                    else passed++;
                end
            end
            ACK_I = STB_O;
            @(negedge CLK_I);
        end
        cmd_valid = 1'b0;
        ACK_I = 1'b0;
        checks++;
        if (ready_vec !== 9'b001001001) $display("FAIL b2b_ready: got %b want 001001001", ready_vec);
        else passed++;
        checks++;
        if (rsp_vec !== 9'b100100100) $display("FAIL b2b_rsp: got %b want 100100100", rsp_vec);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size());
        else passed++;
        @(negedge CLK_I);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
        test_ack_at_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wishbone_master.md
# wishbone_master

Single-outstanding Wishbone classic-cycle initiator that drives the slave-side memory block on the shared 32-bit bus. It turns a valid/ready command from the test or CPU side into one read or write bus cycle, then returns read data or an error flag on a one-cycle response strobe. An optional watchdog aborts cycles that a slave never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, cycles STB_O may stay high without ACK_I before abort; legal range 2..255; ignored without WB_MASTER_TIMEOUT_EN

Ports:
- CLK_I  in  1  single clock; all logic on rising edge
- RST_I  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_adr  in  32  byte address
- cmd_dat  in  32  write data
- cmd_sel  in  4  byte selects
- rsp_valid  out  1  one-cycle response strobe
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  cycle aborted by timeout
- CYC_O, STB_O, WE_O  out  1 each  Wishbone cycle, strobe, write-enable
- ADR_O  out  32  address; SEL_O out 4 byte selects; DAT_O out 32 write data
- DAT_I  in  32  read data from slave
- ACK_I  in  1  slave acknowledge

## Operation
- FSM states: IDLE, BUS, RESP. Encoding comes from the package.
- IDLE: cmd_ready=1. When cmd_valid is high at an edge, latch we/adr/dat/sel and go to BUS.
- BUS: CYC_O=STB_O=1. ADR_O/SEL_O/WE_O are held from the latch. DAT_O=cmd_dat for writes and 0 for reads. cmd_ready=0.
  - ACK_I high at an edge: capture DAT_I into rsp_dat (reads only; writes load 0), set rsp_err=0, go to RESP.
  - Timeout (macro enabled): go to RESP with rsp_err=1 and rsp_dat=0.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. CYC_O and STB_O are 0 in this state. There is no back-pressure on the response.
- ACK_I is ignored when STB_O=0.
- Registered outputs: every output is driven from flops. cmd_ready is decoded from the state register.
- Watchdog counter is 8 bits. It clears on entry to BUS and increments each BUS cycle without ACK_I. Timeout fires when the count reaches TIMEOUT_CYCLES-1 and ACK_I is low.
- ACK_I and the timeout condition in the same cycle: ACK wins, and the cycle completes normally with rsp_err=0.

## Timing
- Reset values: state IDLE; CYC_O, STB_O, WE_O, rsp_valid and rsp_err are 0; ADR_O, DAT_O, SEL_O and rsp_dat are 0.
- cmd_ready is 1 in the first cycle after reset deassertion.
- Command accepted at edge 0: CYC_O/STB_O high in cycle 1.
- ACK_I sampled at edge k (k≥1): STB_O low in cycle k+1 and rsp_valid high in cycle k+1.
- Minimum turnaround from acceptance to next cmd_ready=1 is 3 cycles.
- With a zero-wait slave, one command is accepted every 3 cycles.
- RST_I asserted mid-cycle drops CYC_O/STB_O asynchronously. No response is issued for the aborted command.
- Timeout: with no ACK, STB_O is high for exactly TIMEOUT_CYCLES cycles. rsp_valid with rsp_err=1 is high in the next cycle.

## Configuration
- WB_MASTER_TIMEOUT_EN defined: the watchdog counter and abort path are present.
- WB_MASTER_TIMEOUT_EN undefined: no counter. BUS waits indefinitely for ACK_I, and rsp_err is tied to 0.

## Structure
- Package wb_pkg holds:
  - the state enum type
  - WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4
  - a packed wb_cmd_t struct {we, adr, dat, sel} used for the command latch
- One sub-module is natural: wb_timeout_counter (clear, enable, expire output, TIMEOUT_CYCLES parameter). It is instantiated only under WB_MASTER_TIMEOUT_EN.

## Test plan
- Reset: hold RST_I high for 3 cycles, then release. All outputs are 0 and cmd_ready=1 in the first cycle after release.
- Write: send cmd_we=1, adr=0x10, dat=0xDEADBEEF, sel=0xF to a zero-wait slave. Expect one cycle with CYC_O=STB_O=WE_O=1, ADR_O=0x10, DAT_O=0xDEADBEEF. Then rsp_valid=1 with rsp_err=0 and rsp_dat=0.
- Read back: read adr=0x10 with the slave inserting 2 wait states. STB_O stays high for 3 cycles, then rsp_valid=1 with rsp_dat=0xDEADBEEF.
- Timeout (macro on, TIMEOUT_CYCLES=4): read from a slave that never ACKs. STB_O is high for 4 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
- ACK and timeout together (macro on): ACK_I arrives on the 4th cycle. Expect rsp_err=0 and correct data.
- Reset mid-cycle: assert RST_I asynchronously while STB_O=1. CYC_O falls before the next edge and no rsp_valid occurs. The next command after release completes normally.
